// File: rtl/n5_flash_xip_ctrl.sv
// n5_flash_xip_ctrl: AHB-Lite read-only execute-in-place controller for a
// quad SPI program flash. Every read becomes a Quad I/O Fast Read (0xEB);
// writes get a two-cycle AHB ERROR response.
// Optional feature: define N5_FLASH_LINEBUF_EN to add a 16-byte line buffer
// (hits return with zero wait states, misses fetch the whole aligned line).
module n5_flash_xip_ctrl #(
    parameter int         ADDR_BITS  = 24,
    parameter logic [7:0] MODE_BYTE  = 8'h00,
    parameter int         DUMMY_CLKS = 4
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        HRESP,
    input  logic [3:0]  fdi,
    output logic [3:0]  fdo,
    output logic        fdoe,
    output logic        fsclk,
    output logic        fcen
);

    localparam logic [7:0] CMD_OP     = 8'hEB;
    localparam logic [5:0] ADDR_LAST  = 6'(ADDR_BITS / 4 - 1);
    localparam logic [5:0] DUMMY_LAST = 6'(DUMMY_CLKS - 1);
`ifdef N5_FLASH_LINEBUF_EN
    localparam int         SR_W       = 128;
    localparam logic [5:0] DATA_LAST  = 6'd31;
`else
    localparam int         SR_W       = 32;
    localparam logic [5:0] DATA_LAST  = 6'd7;
`endif

    typedef enum logic [3:0] {
        IDLE, CMD, ADDR, MODE, DUMMY, DATA, DESEL, ERR1, ERR2
    } state_t;

    state_t                 state;
    state_t                 nxt_state;
    logic [5:0]             cnt;
    logic [5:0]             nxt_cnt;
    logic                   ph;
    logic                   pend;
    logic                   accept;
    logic                   hit;
    logic                   launch;
    logic [31:0]            hit_word;
    logic [ADDR_BITS-3:0]   addr_q;
    logic [ADDR_BITS-1:0]   faddr;
    logic [SR_W-5:0]        sr;
    logic [SR_W-1:0]        sr_next;
    logic [31:0]            data_word;
    logic                   unused_bits;

`ifdef N5_FLASH_LINEBUF_EN
    logic [31:0]            lb_word [4];
    logic [ADDR_BITS-5:0]   lb_tag;
    logic                   lb_valid;

    assign hit      = lb_valid & (lb_tag == HADDR[ADDR_BITS-1:4]);
    assign hit_word = lb_word[HADDR[3:2]];
    assign faddr    = {addr_q[ADDR_BITS-3:2], 4'b0000};
`else
    assign hit      = 1'b0;
    assign hit_word = 32'h0;
    assign faddr    = {addr_q, 2'b00};
`endif

    // Size, the sequential/non-sequential hint and address bits outside the
    // flash array play no part in a read.
    assign unused_bits = ^{HSIZE, HTRANS[0], HADDR[31:ADDR_BITS], HADDR[1:0]};

    // A transfer can only be taken while this slave is ready for a new one;
    // a read arriving in DESEL waits one cycle so CEb stays high long enough.
    assign accept = HSEL & HTRANS[1] & HREADY &
                    (((state == IDLE) & ~pend) | (state == DESEL) | (state == ERR2));
    assign launch = pend | (accept & ~HWRITE & ~hit & (state != DESEL));

    assign sr_next = {sr, fdi};

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic drives_bus(input state_t st);
        return (st == CMD) || (st == ADDR) || (st == MODE);
    endfunction

    // Nibble presented on the SIO pins during period c of phase st.
    function automatic logic [3:0] out_nib(input state_t st, input logic [5:0] c,
                                           input logic [ADDR_BITS-1:0] a);
        logic [ADDR_BITS-1:0] sh;
        logic [7:0]           amt;
        amt = {ADDR_LAST - c, 2'b00};
        sh  = a >> amt;
        case (st)
            CMD:     out_nib = {3'b111, CMD_OP[3'd7 - c[2:0]]};
            ADDR:    out_nib = sh[3:0];
            MODE:    out_nib = (c == 6'd0) ? MODE_BYTE[7:4] : MODE_BYTE[3:0];
            default: out_nib = 4'hF;
        endcase
    endfunction

    // Phase/period sequencing applied at the end of each SCK period.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt + 6'd1;
        case (state)
            CMD:     if (cnt == 6'd7)      begin nxt_state = ADDR;  nxt_cnt = 6'd0; end
            ADDR:    if (cnt == ADDR_LAST) begin nxt_state = MODE;  nxt_cnt = 6'd0; end
            MODE:    if (cnt == 6'd1)      begin nxt_state = DUMMY; nxt_cnt = 6'd0; end
            DUMMY:   if (cnt == DUMMY_LAST) begin nxt_state = DATA; nxt_cnt = 6'd0; end
            DATA:    if (cnt == DATA_LAST) begin nxt_state = DESEL; nxt_cnt = 6'd0; end
            default: nxt_cnt = 6'd0;
        endcase
    end

    // Pick the requested word out of the freshly assembled data stream.
    always_comb begin
`ifdef N5_FLASH_LINEBUF_EN
        case (addr_q[1:0])
            2'd0:    data_word = sr_next[127:96];
            2'd1:    data_word = sr_next[95:64];
            2'd2:    data_word = sr_next[63:32];
            default: data_word = sr_next[31:0];
        endcase
`else
        data_word = sr_next;
`endif
    end

    // Address latch, nibble assembly and line fill (no reset needed).
    always_ff @(posedge HCLK) begin
        if (accept && !HWRITE) begin
            addr_q <= HADDR[ADDR_BITS-1:2];
        end
        if (state == DATA && ph) begin
            sr <= sr_next[SR_W-5:0];
`ifdef N5_FLASH_LINEBUF_EN
            if (cnt == DATA_LAST) begin
                lb_word[0] <= bswap(sr_next[127:96]);
                lb_word[1] <= bswap(sr_next[95:64]);
                lb_word[2] <= bswap(sr_next[63:32]);
                lb_word[3] <= bswap(sr_next[31:0]);
                lb_tag     <= addr_q[ADDR_BITS-3:2];
            end
`endif
        end
    end

    // Main FSM: bus handshake plus all flash pin sequencing, outputs registered.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= IDLE;
            cnt       <= 6'd0;
            ph        <= 1'b0;
            pend      <= 1'b0;
            fcen      <= 1'b1;
            fsclk     <= 1'b0;
            fdoe      <= 1'b0;
            fdo       <= 4'hF;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            HRDATA    <= 32'h0;
`ifdef N5_FLASH_LINEBUF_EN
            lb_valid  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DESEL, ERR2: begin
                    state     <= IDLE;
                    fcen      <= 1'b1;
                    fsclk     <= 1'b0;
                    fdoe      <= 1'b0;
                    fdo       <= 4'hF;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b0;
                    if (launch) begin
                        pend      <= 1'b0;
                        state     <= CMD;
                        cnt       <= 6'd0;
                        ph        <= 1'b0;
                        fcen      <= 1'b0;
                        fdoe      <= 1'b1;
                        fdo       <= {3'b111, CMD_OP[7]};
                        HREADYOUT <= 1'b0;
                    end else if (accept && HWRITE) begin
                        state     <= ERR1;
                        HREADYOUT <= 1'b0;
                        HRESP     <= 1'b1;
                    end else if (accept && hit) begin
                        HRDATA    <= hit_word;
                    end else if (accept) begin
                        pend      <= 1'b1;
                        HREADYOUT <= 1'b0;
                    end
                end
                ERR1: begin
                    state     <= ERR2;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b1;
                end
                default: begin
                    if (!ph) begin
                        ph    <= 1'b1;
                        fsclk <= 1'b1;
                    end else begin
                        ph    <= 1'b0;
                        fsclk <= 1'b0;
                        state <= nxt_state;
                        cnt   <= nxt_cnt;
                        if (nxt_state == DESEL) begin
                            fcen      <= 1'b1;
                            fdoe      <= 1'b0;
                            fdo       <= 4'hF;
                            HREADYOUT <= 1'b1;
                            HRDATA    <= bswap(data_word);
`ifdef N5_FLASH_LINEBUF_EN
                            lb_valid  <= 1'b1;
`endif
                        end else begin
                            fdoe <= drives_bus(nxt_state);
                            fdo  <= out_nib(nxt_state, nxt_cnt, faddr);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_n5_flash_xip_ctrl.sv
// Directed testbench for n5_flash_xip_ctrl with a behavioural quad SPI flash.
module tb_n5_flash_xip_ctrl;

`ifdef N5_FLASH_LINEBUF_EN
    localparam int          WORD_LAT   = 105;
    localparam int          RISES      = 52;
    localparam int          REPEAT_LAT = 1;
    localparam int          B2B_LAT    = 1;
    localparam logic [31:0] TOP_FADDR  = 32'h000FFFF0;
`else
    localparam int          WORD_LAT   = 57;
    localparam int          RISES      = 28;
    localparam int          REPEAT_LAT = 57;
    localparam int          B2B_LAT    = 58;
    localparam logic [31:0] TOP_FADDR  = 32'h000FFFFC;
`endif
    localparam int RC_DATA = 20;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        HRESP;
    logic [3:0]  fdi = 4'h0;
    logic [3:0]  fdo;
    logic        fdoe;
    logic        fsclk;
    logic        fcen;

    int n_cmp = 0;
    int n_bad = 0;

    assign HREADY = HREADYOUT;

    always #5 HCLK = ~HCLK;

    n5_flash_xip_ctrl dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP),
        .fdi(fdi), .fdo(fdo), .fdoe(fdoe), .fsclk(fsclk), .fcen(fcen)
    );

    // Flash contents: preloaded bytes, otherwise the low address byte.
    function automatic logic [7:0] byte_at(input logic [23:0] a);
        case (a)
            24'h000010: return 8'h11;
            24'h000011: return 8'h22;
            24'h000012: return 8'h33;
            24'h000013: return 8'h44;
            24'h0FFFFC: return 8'hFF;
            24'h0FFFFD: return 8'hEE;
            24'h0FFFFE: return 8'hDD;
            24'h0FFFFF: return 8'hCC;
            default:    return a[7:0];
        endcase
    endfunction

    // Flash model: shifts in command/address/mode on SCK rise.
    int         rc = 0;
    int         last_rises = 0;
    int         pin_err = 0;
    logic [7:0]  cmd_sh = 8'h0, last_cmd = 8'h0;
    logic [23:0] addr_sh = 24'h0, last_addr = 24'h0;
    logic [7:0]  mode_sh = 8'h0, last_mode = 8'h0;

    always @(posedge fsclk or posedge fcen) begin
        if (fcen) begin
            if (rc != 0) begin
                last_rises = rc;
                last_cmd   = cmd_sh;
                last_addr  = addr_sh;
                last_mode  = mode_sh;
            end
            rc = 0;
        end else begin
            if (rc < 8) begin
                cmd_sh = {cmd_sh[6:0], fdo[0]};
                if (fdo[3:1] !== 3'b111) pin_err++;
            end else if (rc < 14) begin
                addr_sh = {addr_sh[19:0], fdo};
            end else if (rc < 16) begin
                mode_sh = {mode_sh[3:0], fdo};
            end
            rc++;
            if (fdoe !== (rc <= 16)) pin_err++;
        end
    end

    // Flash model: drives the next data nibble after each SCK fall.
    always @(negedge fsclk) begin
        if (!fcen && rc >= RC_DATA) begin
            int         j;
            logic [7:0] b;
            j = rc - RC_DATA;
            b = byte_at(addr_sh + 24'(j / 2));
            fdi = (j % 2 == 0) ? b[7:4] : b[3:0];
        end
    end

    // Pin monitors: CEb high-run length, CEb falls, SCK while deselected.
    int hi_run = 0, last_hi = 0, sck_err = 0, fcen_falls = 0;
    always @(negedge HCLK) begin
        if (fcen === 1'b1) hi_run++;
        else begin
            if (hi_run != 0) last_hi = hi_run;
            hi_run = 0;
        end
        if (fcen === 1'b1 && fsclk !== 1'b0) sck_err++;
    end
    always @(negedge fcen) fcen_falls++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge HCLK); #1; end
    endtask

    // Issue one read (caller is 1 time unit after an edge with HREADYOUT high).
    task automatic ahb_read(input string tag, input logic [31:0] a,
                            input logic [31:0] exp_data, input int exp_lat);
        int lat;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        lat = 1;
        while (HREADYOUT !== 1'b1 && lat < 400) begin
            @(posedge HCLK); #1;
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " data"}, HRDATA, exp_data);
        chk({tag, " resp"}, {31'b0, HRESP}, 32'h0);
    endtask

    initial begin
        int f0;
        HRESETn = 1'b0; HSEL = 1'b0; HADDR = 32'h0; HTRANS = 2'b00;
        HWRITE = 1'b0; HSIZE = 3'b010;
        #7;
        chk("rst fcen",      {31'b0, fcen},      32'h1);
        chk("rst fsclk",     {31'b0, fsclk},     32'h0);
        chk("rst fdoe",      {31'b0, fdoe},      32'h0);
        chk("rst fdo",       {28'b0, fdo},       32'hF);
        chk("rst hreadyout", {31'b0, HREADYOUT}, 32'h1);
        chk("rst hresp",     {31'b0, HRESP},     32'h0);
        chk("rst hrdata",    HRDATA,             32'h0);
        #5 HRESETn = 1'b1;
        @(posedge HCLK); #1;

        // Plain word read
        ahb_read("rd_0x10", 32'h0000_0010, 32'h4433_2211, WORD_LAT);
        chk("rd_0x10 sck rises", 32'(last_rises), 32'(RISES));
        chk("rd_0x10 cmd",       {24'b0, last_cmd},  32'hEB);
        chk("rd_0x10 addr",      {8'b0, last_addr},  32'h0000_0010);
        chk("rd_0x10 mode",      {24'b0, last_mode}, 32'h00);
        idle(2);

        // Top of the array, then the same word with junk upper address bits
        ahb_read("rd_top", 32'h000F_FFFC, 32'hCCDD_EEFF, WORD_LAT);
        chk("rd_top addr", {8'b0, last_addr}, TOP_FADDR);
        idle(2);
        ahb_read("rd_top_hi", 32'hFF0F_FFFC, 32'hCCDD_EEFF, REPEAT_LAT);
        idle(2);

        // Write gets a two-cycle ERROR and never touches the flash
        f0 = fcen_falls;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h0000_0020;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
        chk("wr c1 hreadyout", {31'b0, HREADYOUT}, 32'h0);
        chk("wr c1 hresp",     {31'b0, HRESP},     32'h1);
        chk("wr c1 fcen",      {31'b0, fcen},      32'h1);
        @(posedge HCLK); #1;
        chk("wr c2 hreadyout", {31'b0, HREADYOUT}, 32'h1);
        chk("wr c2 hresp",     {31'b0, HRESP},     32'h1);
        chk("wr c2 fcen",      {31'b0, fcen},      32'h1);
        @(posedge HCLK); #1;
        chk("wr c3 hresp",     {31'b0, HRESP},     32'h0);
        chk("wr fcen falls",   32'(fcen_falls),    32'(f0));
        idle(2);

        // Back-to-back reads
        ahb_read("b2b_0x0", 32'h0000_0000, 32'h0302_0100, WORD_LAT);
        ahb_read("b2b_0x4", 32'h0000_0004, 32'h0706_0504, B2B_LAT);
`ifndef N5_FLASH_LINEBUF_EN
        chk("b2b fcen high cycles", 32'(last_hi), 32'd2);
`endif
        idle(2);

        // Reset in the middle of the DATA phase
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h0000_0080;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        idle(45);
        chk("mid fcen low", {31'b0, fcen},  32'h0);
        chk("mid fsclk",    {31'b0, fsclk}, 32'h1);
        #2 HRESETn = 1'b0;
        #1;
        chk("arst fcen",      {31'b0, fcen},      32'h1);
        chk("arst fsclk",     {31'b0, fsclk},     32'h0);
        chk("arst fdoe",      {31'b0, fdoe},      32'h0);
        chk("arst fdo",       {28'b0, fdo},       32'hF);
        chk("arst hreadyout", {31'b0, HREADYOUT}, 32'h1);
        chk("arst hresp",     {31'b0, HRESP},     32'h0);
        chk("arst hrdata",    HRDATA,             32'h0);
        #3 HRESETn = 1'b1;
        @(posedge HCLK); #1;
        ahb_read("rd_after_rst", 32'h0000_0010, 32'h4433_2211, WORD_LAT);
        chk("rd_after_rst sck rises", 32'(last_rises), 32'(RISES));

`ifdef N5_FLASH_LINEBUF_EN
        idle(2);
        ahb_read("lb_miss_0x40", 32'h0000_0040, 32'h4342_4140, WORD_LAT);
        chk("lb_miss_0x40 addr", {8'b0, last_addr}, 32'h0000_0040);
        idle(2);
        f0 = fcen_falls;
        ahb_read("lb_hit_0x44", 32'h0000_0044, 32'h4746_4544, 1);
        chk("lb_hit_0x44 fcen falls", 32'(fcen_falls), 32'(f0));
        idle(2);
        ahb_read("lb_miss_0x50", 32'h0000_0050, 32'h5352_5150, WORD_LAT);
        chk("lb_miss_0x50 fcen falls", 32'(fcen_falls), 32'(f0 + 1));
`endif

        idle(2);
        chk("sck while deselected", 32'(sck_err), 32'd0);
        chk("sio pin errors",       32'(pin_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
